// File: rtl/serial_readout_master.sv
// Readout master for the decimation filter's serial port: on a new_data fall it opens
// a cs_n frame, clocks WIDTH bits in MSB-first on sclk rises and strobes the parallel word.
module serial_readout_master #(
  parameter int WIDTH     = 12,
  parameter int HALF      = 5,
  parameter int START_DLY = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             new_data,
  input  logic             serial_data_in,
  output logic             cs_n,
  output logic             sclk,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             overrun
);

  localparam int MAXC = (HALF > START_DLY) ? HALF : START_DLY;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int BW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_SETUP = 3'd2;
  localparam logic [2:0] S_HIGH  = 3'd3;
  localparam logic [2:0] S_LOW   = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;

  logic [2:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] do_q, do_d;
  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic             dv_q, dv_d;
  logic             ov_q, ov_d;
  logic             nd_q;
  logic             trig;
  logic             busy;
  logic             cnt_done;

  assign trig     = nd_q & ~new_data;
  // The data_valid cycle still counts as busy so a trigger there is reported, not taken.
  assign busy     = (state_q != S_IDLE) | dv_q;
  assign cnt_done = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    do_d    = do_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    dv_d    = 1'b0;
    ov_d    = trig & busy;
    case (state_q)
      S_IDLE: begin
        if (trig && !busy && en) begin
          state_d = S_WAIT;
          cnt_d   = CW'(START_DLY - 1);
        end
      end
      S_WAIT: begin
        if (cnt_done) begin
          cs_d    = 1'b0;
          state_d = S_SETUP;
          cnt_d   = CW'(HALF - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_SETUP: begin
        if (cnt_done) begin
          sclk_d  = 1'b1;
          sr_d    = {sr_q[WIDTH-2:0], serial_data_in};
          bit_d   = BW'(WIDTH - 1);
          state_d = S_HIGH;
          cnt_d   = CW'(HALF - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HIGH: begin
        if (cnt_done) begin
          sclk_d  = 1'b0;
          state_d = S_LOW;
          cnt_d   = CW'(HALF - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_LOW: begin
        if (cnt_done) begin
          cnt_d = CW'(HALF - 1);
          if (bit_q != '0) begin
            sclk_d  = 1'b1;
            sr_d    = {sr_q[WIDTH-2:0], serial_data_in};
            bit_d   = bit_q - 1'b1;
            state_d = S_HIGH;
          end else begin
            state_d = S_HOLD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_done) begin
          cs_d    = 1'b1;
          do_d    = sr_q;
          dv_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      do_q    <= '0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      dv_q    <= 1'b0;
      ov_q    <= 1'b0;
      nd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      do_q    <= do_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      dv_q    <= dv_d;
      ov_q    <= ov_d;
      nd_q    <= new_data;
    end
  end

  assign cs_n       = cs_q;
  assign sclk       = sclk_q;
  assign data_out   = do_q;
  assign data_valid = dv_q;
  assign overrun    = ov_q;

endmodule

// File: tb/tb_serial_readout_master.sv
// Bench for serial_readout_master: a slave shift model feeds the port and a timing
// model derived from the frame formula predicts cs_n, sclk, data_valid and overrun each cycle.
module tb_serial_readout_master;

  localparam int W   = 12;
  localparam int H   = 5;
  localparam int S   = 4;
  localparam int LEN = S + 2 * H * (W + 1);

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         new_data;
  logic         sdi;
  logic         cs_n;
  logic         sclk;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         overrun;

  int           vectors;
  int           miscompares;
  int           cyc;
  int           m_e;
  int           m_ov_cyc;
  logic         m_ndp;
  logic [W-1:0] m_word;
  logic [W-1:0] m_do;
  logic [W-1:0] slave_word;
  logic [W-1:0] sh;
  logic [W-1:0] words[3];

  serial_readout_master #(.WIDTH(W), .HALF(H), .START_DLY(S)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en             (en),
    .new_data       (new_data),
    .serial_data_in (sdi),
    .cs_n           (cs_n),
    .sclk           (sclk),
    .data_out       (data_out),
    .data_valid     (data_valid),
    .overrun        (overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      if (miscompares <= 30)
        $display("FAIL %s @cyc %0d: got 0x%0h want 0x%0h", tag, cyc, got, exp);
    end
  endtask

  // Slave: present the MSB when selected, advance one bit after every sclk rise.
  initial begin
    sh = '0;
    forever begin
      @(negedge cs_n);
      sh  = slave_word;
      sdi = sh[W-1];
    end
  end
  initial begin
    forever begin
      @(posedge sclk);
      #1;
      sh  = {sh[W-2:0], 1'b0};
      sdi = sh[W-1];
    end
  end

  // Reference: a frame starts at edge m_e; everything else is offset arithmetic from it.
  initial begin
    int  k;
    logic trig;
    logic busy;
    cyc = 0; m_e = -100000; m_ov_cyc = -1; m_ndp = 1'b0; m_word = '0; m_do = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst_n) begin
        m_ndp = 1'b0; m_e = -100000; m_do = '0;
      end else begin
        k = cyc - m_e;
        if (k == LEN) m_do = m_word;
        trig = m_ndp && !new_data;
        busy = (k >= 1) && (k <= LEN + 1);
        if (trig && busy) m_ov_cyc = cyc;
        if (trig && !busy && en) begin
          m_e    = cyc;
          m_word = slave_word;
        end
        m_ndp = new_data;
      end
    end
  end

  initial begin
    int   k;
    logic e_cs, e_sclk;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_dv", 32'(data_valid), 32'd0);
        check("rst_ov", 32'(overrun), 32'd0);
        check("rst_data", 32'(data_out), 32'd0);
      end else begin
        k      = cyc - m_e;
        e_cs   = !(k >= S && k < LEN);
        e_sclk = (k >= S + H) && (k < S + 2 * H * W) && (((k - S - H) % (2 * H)) < H);
        check("cs_n", 32'(cs_n), 32'(e_cs));
        check("sclk", 32'(sclk), 32'(e_sclk));
        check("data_valid", 32'(data_valid), 32'(k == LEN));
        check("overrun", 32'(overrun), 32'(m_ov_cyc == cyc));
        check("data_out", 32'(data_out), 32'(m_do));
      end
    end
  end

  task automatic pulse();
    @(posedge clk); #2 new_data = 1'b1;
    @(posedge clk); #2 new_data = 1'b0;
  endtask

  task automatic wait_dv(input string tag, input logic [W-1:0] exp);
    bit seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (data_valid) seen = 1'b1;
    end
    if (seen) check(tag, 32'(data_out), 32'(exp));
    else check({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic wait_sclk_rises(input int n);
    int   cnt = 0;
    logic prev = 1'b0;
    for (int i = 0; i < 400 && cnt < n; i++) begin
      @(negedge clk);
      if (sclk && !prev) cnt++;
      prev = sclk;
    end
    if (cnt < n) check("sclk_rise_timeout", 32'(cnt), 32'(n));
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; en = 1'b1; new_data = 1'b0; sdi = 1'b0; slave_word = '0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2 new_data = ~new_data;
    end
    @(posedge clk); #2 new_data = 1'b0;
    @(posedge clk); #2 rst_n = 1'b1;
    repeat (3) @(posedge clk);

    // Single frame
    slave_word = 12'hA5C;
    pulse();
    wait_dv("single", 12'hA5C);
    repeat (5) @(posedge clk);

    // Back-to-back, each trigger on the first edge after the data_valid cycle
    words[0] = 12'hFFF; words[1] = 12'h000; words[2] = 12'h801;
    slave_word = words[0];
    pulse();
    for (int i = 1; i < 3; i++) begin
      @(posedge clk); #2 new_data = 1'b1;
      wait_dv("b2b", words[i-1]);
      slave_word = words[i];
      @(posedge clk); #2 new_data = 1'b0;
    end
    wait_dv("b2b_last", words[2]);
    repeat (5) @(posedge clk);

    // Trigger landing in the data_valid cycle is an overrun
    slave_word = 12'h6B2;
    pulse();
    @(posedge clk); #2 new_data = 1'b1;
    wait_dv("dv_cycle_frame", 12'h6B2);
    #1 new_data = 1'b0;
    repeat (150) @(posedge clk);

    // Overrun mid-frame
    slave_word = 12'h123;
    pulse();
    repeat (57) @(posedge clk);
    pulse();
    wait_dv("overrun_frame", 12'h123);
    repeat (5) @(posedge clk);

    // Reset mid-frame
    slave_word = 12'h5A5;
    pulse();
    wait_sclk_rises(6);
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    check("async_cs_n", 32'(cs_n), 32'd1);
    check("async_sclk", 32'(sclk), 32'd0);
    check("async_data", 32'(data_out), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    slave_word = 12'h3C3;
    pulse();
    wait_dv("after_reset", 12'h3C3);
    repeat (5) @(posedge clk);

    // Enable low at trigger, then dropped mid-frame
    en = 1'b0;
    slave_word = 12'h777;
    pulse();
    repeat (150) @(posedge clk);
    #2 en = 1'b1;
    slave_word = 12'h9E1;
    pulse();
    repeat (19) @(posedge clk);
    #2 en = 1'b0;
    wait_dv("en_drop", 12'h9E1);
    @(posedge clk); #2 en = 1'b1;
    repeat (5) @(posedge clk);

    // Randomized frames with occasional disabled triggers and overruns
    for (int it = 0; it < 10; it++) begin
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #2;
      slave_word = W'($urandom_range(0, 4095));
      en = ($urandom_range(0, 3) != 0);
      pulse();
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 130)) @(posedge clk);
        pulse();
      end
      repeat (140) @(posedge clk);
    end

    #2 en = 1'b1;
    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_readout_master.md
Name: serial_readout_master

Overview:
- Clocked reader for the decimation filter's 12-bit serial readout port (cs_n / sclk / serial_data_out).
- Waits for the filter's new_data pulse to end, then opens a chip-select frame and generates WIDTH sclk pulses.
- Shifts the word in MSB-first and presents it as a parallel word with a one-cycle valid strobe.
- Sits in the same clock domain as the filter and replaces the bench-driven readout in integrated builds.

Parameters:
WIDTH, 12, bits per frame (MSB first)
HALF, 5, clk cycles per sclk half-period; also the cs_n-low-to-first-sclk setup and the last-fall-to-cs_n-high hold (>=1)
START_DLY, 4, clk cycles from detected new_data fall to cs_n low (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  enables starting new frames; a frame already in progress always completes
new_data  input  1  filter output-ready flag, synchronous to clk
serial_data_in  input  1  filter serial_data_out
cs_n  output  1  chip select to filter, active low
sclk  output  1  serial clock to filter
data_out  output  WIDTH  last completed word
data_valid  output  1  one-cycle strobe, data_out updated
overrun  output  1  one-cycle strobe, trigger ignored because busy

Behaviour:
- Reset (async assert, sync release): cs_n=1, sclk=0, data_out=0, data_valid=0, overrun=0, state IDLE, shift reg=0, new_data history reg=0.
- Trigger: rising edge E0 where registered previous new_data=1 and current new_data=0.
- Trigger is accepted only in IDLE with en=1; in IDLE with en=0 it is dropped silently.
- States and timing, all counts in clk edges from E0:
  - IDLE -> WAIT at E0. cs_n<=0 at E0+START_DLY, then -> SETUP.
  - First sclk rise at E0+START_DLY+HALF. On the same edge, serial_data_in (pre-edge value) is shifted in as bit WIDTH-1; -> HIGH.
  - HIGH: sclk<=0 after HALF cycles; -> LOW.
  - LOW: after HALF cycles, if bits remain, sample the next bit, set sclk<=1 and -> HIGH; otherwise -> HOLD.
  - Bit i is sampled at E0+START_DLY+HALF+2*HALF*(WIDTH-1-i).
  - HOLD: HALF cycles, then cs_n<=1, data_out<=shift reg, data_valid=1 for exactly that cycle; -> IDLE.
  - Defaults: cs_n low E0+4, first rise E0+9, last rise E0+119, last fall E0+124, cs_n high + data_valid at E0+134.
- sclk changes only while cs_n=0; sclk=0 whenever cs_n=1.
- Busy: a trigger in any state other than IDLE, including the data_valid cycle, is ignored, pulses overrun for 1 cycle and does not disturb the frame. This applies regardless of en.
- A trigger on the cycle after data_valid is accepted normally.
- data_out holds its value between frames; it changes only on data_valid.
- Reset mid-frame: cs_n=1 and sclk=0 immediately (async); partial word discarded; no data_valid; data_out=0.
- Counters are sized for max(HALF, START_DLY) and a WIDTH bit index; no wrap within a frame.

Test Plan:
- Reset: hold rst_n=0 with new_data toggling -> cs_n=1, sclk=0, data_out=0x000, data_valid=0, overrun=0 throughout.
- Single frame: slave model drives MSB of 0xA5C at cs_n fall and shifts on each sclk rise; new_data pulse falls at E0 -> exactly 12 sclk rises, cs_n low E0+4..E0+133, data_out=0xA5C with data_valid high only at E0+134.
- Patterns: back-to-back frames of 0xFFF, 0x000, 0x801 with each trigger one cycle after the prior data_valid -> each word captured correctly, one data_valid each, no overrun.
- Overrun: second new_data fall at E0+60 -> overrun pulse 1 cycle, frame timing unchanged, data_out=first word, only one data_valid.
- Reset mid-frame: rst_n=0 after 6th sclk rise -> cs_n=1 and sclk=0 same time, no data_valid; next trigger yields a correct full frame (0x3C3).
- Enable: en=0 at trigger -> no cs_n activity; en dropped to 0 at E0+20 -> frame completes, data_valid at E0+134.
